nios_system_timer_mc: RTL

NIOS_SYSTEM_TIMER_MC -- requirements
Module: nios_system_timer_mc

---
 rtl/nios_system_timer_mc.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/nios_system_timer_mc.sv
// rtl/nios_system_timer_mc.sv - multi-channel down-counting system timer with shared prescaler
module nios_system_timer_mc #(
  parameter int          NUM_CH     = 2,
  parameter int          CNT_W      = 32,
  parameter logic [31:0] DEF_PERIOD = 32'h1DCD64FF,
  parameter int          PRESC_DIV  = 50,
  localparam int         CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int         AW         = 2 + CH_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [AW-1:0]     address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic [NUM_CH-1:0] irq_vec,
  output logic              irq
);

  localparam int               PW       = (PRESC_DIV > 1) ? $clog2(PRESC_DIV) : 1;
  localparam logic [PW-1:0]    P_LAST   = PW'(PRESC_DIV - 1);
  localparam logic [CNT_W-1:0] DEF_P    = DEF_PERIOD[CNT_W-1:0];
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CH_W:0]    NUM_CH_V = (CH_W + 1)'(NUM_CH);

  localparam logic [1:0] REG_STATUS = 2'd0;
  localparam logic [1:0] REG_CTRL   = 2'd1;
  localparam logic [1:0] REG_PERIOD = 2'd2;
  localparam logic [1:0] REG_SNAP   = 2'd3;

  logic [CNT_W-1:0] cnt_q    [NUM_CH];
  logic [CNT_W-1:0] cnt_d    [NUM_CH];
  logic [CNT_W-1:0] period_q [NUM_CH];
  logic [CNT_W-1:0] period_d [NUM_CH];
  logic [CNT_W-1:0] snap_q   [NUM_CH];
  logic [CNT_W-1:0] snap_d   [NUM_CH];
  logic [4:0]       ctrl_q   [NUM_CH];
  logic [4:0]       ctrl_d   [NUM_CH];
  logic [NUM_CH-1:0] run_q, run_d;
  logic [NUM_CH-1:0] to_q, to_d;
  logic [NUM_CH-1:0] hit, en;
  logic [PW-1:0]     presc_q, presc_d;
  logic [31:0]       rdata_q, rdata_d;

  logic [CH_W-1:0] ch_sel;
  logic [1:0]      reg_sel;
  logic            ch_ok;
  logic            wr_en;
  logic            tick;

  assign ch_sel  = address[AW-1:2];
  assign reg_sel = address[1:0];
  assign ch_ok   = ({1'b0, ch_sel} < NUM_CH_V);
  assign wr_en   = chipselect && !write_n && ch_ok;
  assign tick    = (presc_q == P_LAST);

  // Free-running prescaler shared by all channels; wraps on the tick cycle.
  always_comb begin
    presc_d = tick ? '0 : presc_q + PW'(1);
  end

  // Per-channel write decode and count enable.
  always_comb begin
    hit = '0;
    en  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      hit[i] = wr_en && (ch_sel == CH_W'(i));
      en[i]  = run_q[i] && (ctrl_q[i][4] ? tick : 1'b1);
    end
  end

  // Channel next state: status clear first so a coincident timeout keeps TO set,
  // counting suppressed by a period write, register writes override RUN last.
  always_comb begin
    run_d = run_q;
    to_d  = to_q;
    for (int i = 0; i < NUM_CH; i++) begin
      cnt_d[i]    = cnt_q[i];
      period_d[i] = period_q[i];
      snap_d[i]   = snap_q[i];
      ctrl_d[i]   = ctrl_q[i];

      if (hit[i] && reg_sel == REG_STATUS) begin
        to_d[i] = 1'b0;
      end

      if (en[i] && !(hit[i] && reg_sel == REG_PERIOD)) begin
        if (cnt_q[i] == '0) begin
          cnt_d[i] = period_q[i];
          to_d[i]  = 1'b1;
          if (!ctrl_q[i][1]) begin
            run_d[i] = 1'b0;
          end
        end else begin
          cnt_d[i] = cnt_q[i] - CNT_ONE;
        end
      end

      if (hit[i]) begin
        case (reg_sel)
          REG_CTRL: begin
            ctrl_d[i] = writedata[4:0];
            if (writedata[2]) begin
              run_d[i] = 1'b1;
            end else if (writedata[3]) begin
              run_d[i] = 1'b0;
            end
          end
          REG_PERIOD: begin
            period_d[i] = writedata[CNT_W-1:0];
            cnt_d[i]    = writedata[CNT_W-1:0];
            run_d[i]    = 1'b0;
          end
          REG_SNAP: begin
            snap_d[i] = cnt_q[i];
          end
          default: begin
          end
        endcase
      end
    end
  end

  // Read mux, registered below; unmapped channels return zero.
  always_comb begin
    rdata_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_sel == CH_W'(i)) begin
        case (reg_sel)
          REG_STATUS: rdata_d = {30'd0, run_q[i], to_q[i]};
          REG_CTRL:   rdata_d = {27'd0, ctrl_q[i]};
          REG_PERIOD: rdata_d = 32'(period_q[i]);
          default:    rdata_d = 32'(snap_q[i]);
        endcase
      end
    end
  end

  // State registers; reset overrides every same-cycle write and event.
  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q <= '0;
      rdata_q <= '0;
      run_q   <= '0;
      to_q    <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i]    <= DEF_P;
        period_q[i] <= DEF_P;
        snap_q[i]   <= '0;
        ctrl_q[i]   <= '0;
      end
    end else begin
      presc_q <= presc_d;
      rdata_q <= rdata_d;
      run_q   <= run_d;
      to_q    <= to_d;
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i]    <= cnt_d[i];
        period_q[i] <= period_d[i];
        snap_q[i]   <= snap_d[i];
        ctrl_q[i]   <= ctrl_d[i];
      end
    end
  end

  // Interrupts are pure functions of the stored TO and ITO bits.
  always_comb begin
    irq_vec = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      irq_vec[i] = to_q[i] && ctrl_q[i][0];
    end
  end

  assign irq      = |irq_vec;
  assign readdata = rdata_q;

endmodule
